// File: rtl/jtag_master_pkg.sv
// Shared definitions for the JTAG master sequencer: command encodings,
// fixed TMS patterns (bit 0 is driven first) and the sequencer state set.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        CMD_TAP_RESET = 2'b00,
        CMD_SHIFT_IR  = 2'b01,
        CMD_SHIFT_DR  = 2'b10,
        CMD_RUN_IDLE  = 2'b11
    } cmd_type_e;

    typedef enum logic [2:0] {
        IDLE, RSTSEQ, HDR, SHIFT, TRL, RUN, DONE
    } state_e;

    // Five TMS=1 clocks reach Test-Logic-Reset from anywhere, then park in Run-Test/Idle
    localparam logic [7:0] TMS_RESET_PAT  = 8'b0011_1111;
    localparam logic [3:0] TMS_HDR_IR_PAT = 4'b0011;
    localparam logic [3:0] TMS_HDR_DR_PAT = 4'b0010;
    localparam logic [2:0] TMS_TRL_PAT    = 3'b001;

    function automatic logic hdr_tms(input cmd_type_e t, input logic [1:0] idx);
        return (t == CMD_SHIFT_IR) ? TMS_HDR_IR_PAT[idx] : TMS_HDR_DR_PAT[idx];
    endfunction

endpackage

// File: rtl/jtag_master_seq_if.sv
// Command/response handshake between a host and the JTAG master sequencer.
interface jtag_master_seq_if;
    logic        CMD_VALID;
    logic        CMD_RDY;
    logic [1:0]  CMD_TYPE;
    logic [4:0]  CMD_LEN;
    logic [31:0] CMD_DATA;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;

    modport master (output CMD_VALID, CMD_TYPE, CMD_LEN, CMD_DATA,
                    input  CMD_RDY, RSP_VALID, RSP_DATA, RSP_ERR);
    modport slave  (input  CMD_VALID, CMD_TYPE, CMD_LEN, CMD_DATA,
                    output CMD_RDY, RSP_VALID, RSP_DATA, RSP_ERR);
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: TCK_DIV clock cycles per half period, low half first, with
// strobes marking the clock edge on which TCK rises and on which it falls.
module jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);
    logic [7:0] div_cnt;
    logic       half_end;

    assign half_end = en && (div_cnt == 8'(TCK_DIV - 1));
    assign rise     = half_end && !tck;
    assign fall     = half_end && tck;

    // Dropping en parks TCK low with the divider cleared, so every command starts aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (half_end) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/jtag_master_seq.sv
// JTAG master sequencer: runs TAP reset, IR/DR scans and run-idle clocking
// from single commands, returning captured TDO with a one-cycle response.
module jtag_master_seq
    import jtag_master_pkg::*;
#(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic                CLK40,
    input  logic                RST,
    jtag_master_seq_if.slave    bus,
    output logic                TCK,
    output logic                TMS,
    output logic                TDI,
    input  logic                TDO,
    output logic                BUSY
);
    state_e      state, state_d;
    logic [4:0]  bit_cnt, bit_d;
    cmd_type_e   typ, typ_d;
    logic [4:0]  len, len_d;
    logic [31:0] data, data_d;
    logic [31:0] rsp_sh;
    logic        tap_sync, err_flag;
    logic        tms_d, tdi_d;
    logic        accept, tck_en, tck_rise, tck_fall;

    assign accept = bus.CMD_VALID && bus.CMD_RDY;
    assign BUSY   = (state != IDLE);
    assign tck_en = (state != IDLE) && (state != DONE);

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk  (CLK40),
        .rst  (RST),
        .en   (tck_en),
        .tck  (TCK),
        .rise (tck_rise),
        .fall (tck_fall)
    );

    always_comb begin
        state_d = state;
        bit_d   = bit_cnt;
        typ_d   = typ;
        len_d   = len;
        data_d  = data;
        tms_d   = TMS;
        tdi_d   = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                typ_d  = cmd_type_e'(bus.CMD_TYPE);
                len_d  = bus.CMD_LEN;
                data_d = bus.CMD_DATA;
                bit_d  = '0;
                if (typ_d == CMD_TAP_RESET)     state_d = RSTSEQ;
                else if (typ_d == CMD_RUN_IDLE) state_d = RUN;
                else                            state_d = HDR;
            end
            RSTSEQ: if (tck_fall) begin
                if (bit_cnt == 5'd7) state_d = DONE;
                else                 bit_d   = bit_cnt + 5'd1;
            end
            HDR: if (tck_fall) begin
                if (bit_cnt == 5'd3) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_cnt + 5'd1;
                end
            end
            SHIFT: if (tck_fall) begin
                if (bit_cnt == len) begin
                    state_d = TRL;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_cnt + 5'd1;
                end
            end
            TRL: if (tck_fall) begin
                if (bit_cnt == 5'd2) state_d = DONE;
                else                 bit_d   = bit_cnt + 5'd1;
            end
            RUN: if (tck_fall) begin
                if (bit_cnt == len) state_d = DONE;
                else                bit_d   = bit_cnt + 5'd1;
            end
            DONE: begin
                state_d = IDLE;
                bit_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Pins follow the bit about to start, so they change on the same edge TCK falls
        unique case (state_d)
            RSTSEQ: tms_d = TMS_RESET_PAT[bit_d[2:0]];
            HDR:    tms_d = hdr_tms(typ_d, bit_d[1:0]);
            SHIFT: begin
                tms_d = (bit_d == len_d);
                tdi_d = data_d[bit_d];
            end
            TRL:    tms_d = TMS_TRL_PAT[bit_d[1:0]];
            RUN:    tms_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            TMS           <= 1'b1;
            TDI           <= 1'b0;
            bus.CMD_RDY   <= 1'b0;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_ERR   <= 1'b0;
            bus.RSP_DATA  <= '0;
            tap_sync      <= 1'b0;
            err_flag      <= 1'b0;
        end else begin
            state         <= state_d;
            bit_cnt       <= bit_d;
            TMS           <= tms_d;
            TDI           <= tdi_d;
            // Ready drops on the accept edge itself so a held CMD_VALID cannot double-issue
            bus.CMD_RDY   <= (state == IDLE) && !accept;
            bus.RSP_VALID <= (state == DONE);
            bus.RSP_ERR   <= (state == DONE) && err_flag;
            if (state == DONE)
                bus.RSP_DATA <= rsp_sh;
            if (accept)
                err_flag <= (bus.CMD_TYPE != CMD_TAP_RESET) && !tap_sync;
            if (state == RSTSEQ && state_d == DONE)
                tap_sync <= 1'b1;
        end
    end

    always_ff @(posedge CLK40) begin
        typ  <= typ_d;
        len  <= len_d;
        data <= data_d;
        if (accept)
            rsp_sh <= '0;
        else if (state == SHIFT && tck_rise)
            rsp_sh[bit_cnt] <= TDO;
    end
endmodule

// File: tb/tb_jtag_master_seq.sv
// Scoreboard bench for jtag_master_seq: expected TMS/TDI streams, response
// data, error flag and latency are queued per command and checked on RSP_VALID.
module tb_jtag_master_seq;
    localparam int TCK_DIV = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          pulses;
        logic [63:0] tms;
        logic [63:0] tdi;
    } exp_t;

    logic CLK40 = 1'b0;
    logic RST;
    logic TCK, TMS, TDI, TDO, BUSY;

    jtag_master_seq_if bus();

    jtag_master_seq #(.TCK_DIV(TCK_DIV)) dut (
        .CLK40 (CLK40),
        .RST   (RST),
        .bus   (bus),
        .TCK   (TCK),
        .TMS   (TMS),
        .TDI   (TDI),
        .TDO   (TDO),
        .BUSY  (BUSY)
    );

    always #5 CLK40 = ~CLK40;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        q[$];
    exp_t        e_mon;
    bit          sync_m = 0;
    logic [31:0] cur_tdo = '0;

    bit          in_cmd = 0;
    bit          tck_prev = 0;
    int          n_rise = 0;
    int          acc_cyc = 0;
    int          last_rsp_cyc = 0;
    int          last_gap = 0;
    logic [63:0] tms_act = '0;
    logic [63:0] tdi_act = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Independent reference built from the JTAG state diagram walk for each command type
    function automatic exp_t model(input logic [1:0] t, input logic [4:0] l,
                                   input logic [31:0] d, input logic [31:0] tdo, input bit sync);
        exp_t e;
        int   nb = int'(l) + 1;
        int   n;
        e.tms  = '0;
        e.tdi  = '0;
        e.data = '0;
        e.err  = (t != 2'b00) && !sync;
        if (t == 2'b00) begin
            for (int i = 0; i < 6; i++) e.tms[i] = 1'b1;
            n = 8;
        end else if (t == 2'b11) begin
            n = nb;
        end else begin
            e.tms[0] = (t == 2'b01);
            e.tms[1] = 1'b1;
            for (int k = 0; k < nb; k++) begin
                e.tdi[4 + k] = d[k];
                e.data[k]    = tdo[k];
            end
            e.tms[4 + nb - 1] = 1'b1;
            e.tms[4 + nb]     = 1'b1;
            n = 4 + nb + 3;
        end
        e.pulses = n;
        e.lat    = 2 * TCK_DIV * n + 1;
        return e;
    endfunction

    // Target model: presents one return bit per TCK period during the scan phase
    function automatic logic tdo_bit(input int rises, input logic [31:0] pat);
        int idx = rises - 4;
        if (idx >= 0 && idx < 32) return pat[idx];
        return 1'b0;
    endfunction

    assign TDO = tdo_bit(n_rise, cur_tdo);

    always @(posedge CLK40) cyc <= cyc + 1;

    always @(negedge CLK40) begin
        if (RST) begin
            in_cmd   = 0;
            tck_prev = 0;
            n_rise   = 0;
        end else begin
            if (in_cmd && TCK && !tck_prev && n_rise < 64) begin
                tms_act[n_rise] = TMS;
                tdi_act[n_rise] = TDI;
                n_rise++;
            end
            tck_prev = TCK;
            if (bus.RSP_VALID) begin
                if (q.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e_mon = q.pop_front();
                    check_eq("rsp_latency", 64'(cyc - acc_cyc), 64'(e_mon.lat));
                    check_eq("tck_pulses",  64'(n_rise), 64'(e_mon.pulses));
                    check_eq("tms_stream",  tms_act, e_mon.tms);
                    check_eq("tdi_stream",  tdi_act, e_mon.tdi);
                    check_eq("rsp_data",    64'(bus.RSP_DATA), 64'(e_mon.data));
                    check_eq("rsp_err",     64'(bus.RSP_ERR), 64'(e_mon.err));
                end
                in_cmd       = 0;
                last_rsp_cyc = cyc;
            end
            if (bus.CMD_VALID && bus.CMD_RDY) begin
                acc_cyc  = cyc + 1;
                last_gap = acc_cyc - last_rsp_cyc;
                in_cmd   = 1;
                n_rise   = 0;
                tms_act  = '0;
                tdi_act  = '0;
            end
        end
    end

    task automatic send(input logic [1:0] t, input logic [4:0] l, input logic [31:0] d,
                        input logic [31:0] tdo, input bit hold);
        int n = 0;
        q.push_back(model(t, l, d, tdo, sync_m));
        if (t == 2'b00) sync_m = 1;
        @(negedge CLK40);
        cur_tdo       = tdo;
        bus.CMD_TYPE  = t;
        bus.CMD_LEN   = l;
        bus.CMD_DATA  = d;
        bus.CMD_VALID = 1'b1;
        while (!bus.CMD_RDY && n < 1000) begin
            @(negedge CLK40);
            n++;
        end
        if (!bus.CMD_RDY) begin
            check_eq("accept_timeout", 64'(0), 64'(1));
            bus.CMD_VALID = 1'b0;
            return;
        end
        @(posedge CLK40);
        #1;
        if (!hold) bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge CLK40);
            n++;
        end
        if (q.size() != 0) begin
            check_eq("rsp_timeout", 64'(q.size()), 64'(0));
            q.delete();
        end
        repeat (2) @(negedge CLK40);
    endtask

    task automatic check_reset_pins(input string tag);
        check_eq({tag, "_tck"},       64'(TCK), 64'(0));
        check_eq({tag, "_tms"},       64'(TMS), 64'(1));
        check_eq({tag, "_tdi"},       64'(TDI), 64'(0));
        check_eq({tag, "_cmd_rdy"},   64'(bus.CMD_RDY), 64'(0));
        check_eq({tag, "_busy"},      64'(BUSY), 64'(0));
        check_eq({tag, "_rsp_valid"}, 64'(bus.RSP_VALID), 64'(0));
        check_eq({tag, "_rsp_err"},   64'(bus.RSP_ERR), 64'(0));
        check_eq({tag, "_rsp_data"},  64'(bus.RSP_DATA), 64'(0));
    endtask

    initial begin
        logic [31:0] r0, r1;
        RST           = 1'b1;
        bus.CMD_VALID = 1'b0;
        bus.CMD_TYPE  = '0;
        bus.CMD_LEN   = '0;
        bus.CMD_DATA  = '0;
        repeat (3) @(posedge CLK40);
        #1 check_reset_pins("por");
        @(negedge CLK40) RST = 1'b0;
        @(posedge CLK40);
        #1 check_eq("rdy_after_por", 64'(bus.CMD_RDY), 64'(1));

        send(2'b00, 5'd0, 32'h0, 32'h0, 0);              wait_idle();
        send(2'b01, 5'd9, 32'h3C2, 32'h155, 0);          wait_idle();
        send(2'b10, 5'd7, 32'h16, 32'hFFFF_FFA5, 0);     wait_idle();
        r0 = $urandom; r1 = $urandom;
        send(2'b10, 5'd31, r0, r1, 0);                   wait_idle();

        // Held CMD_VALID: second command must wait for ready after the first response
        send(2'b11, 5'd3, 32'h0, 32'h0, 1);
        send(2'b11, 5'd3, 32'h0, 32'h0, 0);
        wait_idle();
        check_eq("b2b_gap", 64'(last_gap), 64'(2));

        // Abort a 32-bit DR scan partway through its sixth shift bit
        r0 = $urandom; r1 = $urandom;
        send(2'b10, 5'd31, r0, r1, 0);
        for (int i = 0; i < 2000 && n_rise < 10; i++) @(negedge CLK40);
        check_eq("abort_reached", 64'(n_rise >= 10), 64'(1));
        #2 RST = 1'b1;
        q.delete();
        sync_m = 0;
        #1 check_reset_pins("abort");
        repeat (2) @(posedge CLK40);
        @(negedge CLK40) RST = 1'b0;
        @(posedge CLK40);
        #1 check_eq("rdy_after_abort", 64'(bus.CMD_RDY), 64'(1));
        repeat (60) @(negedge CLK40);

        send(2'b10, 5'd4, 32'h15, 32'h0A, 0);            wait_idle();
        send(2'b00, 5'd0, 32'h0, 32'h0, 0);              wait_idle();
        send(2'b10, 5'd0, 32'h1, 32'h1, 0);              wait_idle();
        send(2'b01, 5'd4, 32'h0A, 32'h11, 0);            wait_idle();
        send(2'b11, 5'd31, 32'h0, 32'h0, 0);             wait_idle();

        check_eq("sb_empty", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/jtag_master_seq.md
JTAG_MASTER_SEQ -- requirements
Module: jtag_master_seq

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning CLK40 cycles per TCK half-period (TCK = 10 MHz); legal range 1..255.
REQ-002 SHALL have ports: CLK40  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: RST  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: CMD_VALID  in  1  command request; CMD_RDY  out  1  ready to accept.
REQ-005 SHALL have ports: CMD_TYPE  in  2  00 TAP reset, 01 shift IR, 10 shift DR, 11 run-idle.
REQ-006 SHALL have ports: CMD_LEN  in  5  bit count minus 1 (1..32 bits / idle TCKs); CMD_DATA  in  32  TDI data, LSB shifted first.
REQ-007 SHALL have ports: TCK, TMS, TDI  out  1 each  JTAG master drive; TDO  in  1  target return.
REQ-008 SHALL have ports: RSP_VALID  out  1  one-cycle done pulse; RSP_DATA  out  32  captured TDO; RSP_ERR  out  1  TAP not synchronised; BUSY  out  1.

Function
REQ-009 SHALL accept a command only in the cycle CMD_VALID=1 and CMD_RDY=1, latching CMD_TYPE/LEN/DATA; CMD_VALID while CMD_RDY=0 SHALL be ignored.
REQ-010 SHALL use states IDLE, RSTSEQ, HDR, SHIFT, TRL, RUN, DONE; IDLE->RSTSEQ (00), ->HDR (01/10), ->RUN (11); RSTSEQ/RUN/TRL->DONE; HDR->SHIFT->TRL; DONE->IDLE after one cycle.
REQ-011 Each JTAG bit SHALL take 2*TCK_DIV cycles: TMS/TDI updated with TCK falling (low half first), TCK high second half, TDO sampled on the cycle TCK rises.
REQ-012 RSTSEQ SHALL emit 8 bits TMS = 1,1,1,1,1,1,0,0, TDI=0, ending in Run-Test/Idle, and set internal TAP_SYNC.
REQ-013 HDR SHALL emit TMS = 1,1,0,0 for IR, 0,1,0,0 for DR, TDI=0.
REQ-014 SHIFT SHALL emit CMD_LEN+1 bits, TDI = CMD_DATA[k] at bit k, TMS=0 except TMS=1 on last bit.
REQ-015 TRL SHALL emit TMS = 1,0,0, TDI=0 (Update, RTI, RTI).
REQ-016 RUN SHALL emit CMD_LEN+1 bits TMS=0, TDI=0.
REQ-017 TDO sampled on shift bit k SHALL land in RSP_DATA[k]; bits above CMD_LEN SHALL be 0; RSP_DATA SHALL be 0 for types 00/11 and hold until next RSP_VALID.
REQ-018 RSP_VALID SHALL pulse in the cycle after the last bit's high half ends, i.e. bits*2*TCK_DIV+1 cycles after the accept edge; CMD_RDY SHALL reassert in the cycle after RSP_VALID.
REQ-019 Types 01/10/11 issued while TAP_SYNC=0 SHALL still execute and SHALL report RSP_ERR=1 with RSP_VALID; RSP_ERR=0 otherwise.
REQ-020 BUSY SHALL be 1 in all states except IDLE; CMD_RDY = ~BUSY registered.
REQ-021 Bit and divider counters SHALL not wrap mid-command; CMD_LEN=31 SHALL shift exactly 32 bits.

Reset
REQ-022 On RST=1, at any point including mid-shift: state IDLE, TCK=0, TMS=1, TDI=0, CMD_RDY=0, BUSY=0, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0, TAP_SYNC=0, counters 0.
REQ-023 CMD_RDY SHALL rise on the first CLK40 edge after RST deasserts; the partially shifted command SHALL be discarded with no RSP_VALID.

Structure
REQ-024 Shared package jtag_master_pkg SHALL hold CMD_TYPE encodings, the 8-bit reset, 4-bit IR/DR header and 3-bit trailer TMS patterns, and the state enumeration.
REQ-025 TCK half-period tick generation SHALL be sub-module jtag_tck_gen (divider, TCK output, rise/fall strobes).

Verification
REQ-026 After reset, CMD 00 -> exactly 8 TCK pulses, TMS 1,1,1,1,1,1,0,0, RSP_VALID at cycle 33 (TCK_DIV=2), RSP_ERR=0.
REQ-027 CMD 01, LEN=9, DATA=0x3C2 -> 17 TCK pulses; TDI during shift 0,1,0,0,0,0,1,1,1,1; TMS=1 only on 10th shift bit.
REQ-028 CMD 10, LEN=7, DATA=0x16, TDO model returning 0xA5 -> RSP_DATA=0x000000A5, RSP_VALID 61 cycles after accept.
REQ-029 CMD 10 before any CMD 00 -> sequence runs, RSP_ERR=1; subsequent CMD 00 then CMD 10 -> RSP_ERR=0.
REQ-030 Assert RST during shift bit 5 of a 32-bit DR -> TCK=0, TMS=1 immediately, no RSP_VALID, CMD_RDY=1 one edge after release.
REQ-031 Back-to-back CMD 11 LEN=3 with CMD_VALID held high -> second accepted the cycle after first RSP_VALID, 4 TCKs each, TMS=0 throughout.
